// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch debouncer: FSM encodings, default debounce length
// and the counter type used by every channel.
package switch_debouncer_pkg;

  localparam int DEFAULT_DEBOUNCE_CNT = 250;

  typedef logic [1:0]  state_t;
  typedef logic [15:0] count_t;

  localparam state_t STABLE_LOW  = 2'd0;
  localparam state_t WAIT_HIGH   = 2'd1;
  localparam state_t STABLE_HIGH = 2'd2;
  localparam state_t WAIT_LOW    = 2'd3;

endpackage

// File: rtl/switch_debouncer_if.sv
// One debounce channel as seen from outside: the raw switch level in, the clean level out.
interface switch_debouncer_if;

  logic raw;
  logic level;

  modport master (output raw, input level);
  modport slave  (input raw, output level);

endinterface

// File: rtl/switch_debouncer_channel.sv
// A single debounce channel: two-flop synchronizer, four-state FSM and stability counter.
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int c_DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT
) (
  input  logic         i_clock,
  input  logic         i_reset,
  switch_debouncer_if.slave ch
);

  localparam count_t LAST = count_t'(c_DEBOUNCE_CNT - 1);

  logic   sync_1;
  logic   sync_2;
  state_t state;
  count_t count;
  logic   level;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= ch.raw;
      sync_2 <= sync_1;
    end
  end

  // A return to the old level always wins over reaching the terminal count.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= STABLE_LOW;
      count <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        STABLE_LOW: begin
          if (sync_2) begin
            state <= WAIT_HIGH;
            count <= 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (!sync_2) begin
            state <= STABLE_LOW;
            count <= '0;
          end else if (count == LAST) begin
            state <= STABLE_HIGH;
            count <= '0;
            level <= 1'b1;
          end else begin
            count <= count + 16'd1;
          end
        end
        STABLE_HIGH: begin
          if (!sync_2) begin
            state <= WAIT_LOW;
            count <= 16'd1;
          end
        end
        WAIT_LOW: begin
          if (sync_2) begin
            state <= STABLE_HIGH;
            count <= '0;
          end else if (count == LAST) begin
            state <= STABLE_LOW;
            count <= '0;
            level <= 1'b0;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: begin
          state <= STABLE_LOW;
          count <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

  assign ch.level = level;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the enable and two select switches and flags changes of the select pair.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int c_DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable_raw,
  input  logic i_switch_1_raw,
  input  logic i_switch_2_raw,
  output logic o_enable,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_sel_change
);

  switch_debouncer_if enable_ch ();
  switch_debouncer_if switch_1_ch ();
  switch_debouncer_if switch_2_ch ();

  logic [1:0] sel_q;

  assign enable_ch.raw   = i_enable_raw;
  assign switch_1_ch.raw = i_switch_1_raw;
  assign switch_2_ch.raw = i_switch_2_raw;

  debounce_channel #(.c_DEBOUNCE_CNT(c_DEBOUNCE_CNT)) u_enable (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .ch      (enable_ch)
  );

  debounce_channel #(.c_DEBOUNCE_CNT(c_DEBOUNCE_CNT)) u_switch_1 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .ch      (switch_1_ch)
  );

  debounce_channel #(.c_DEBOUNCE_CNT(c_DEBOUNCE_CNT)) u_switch_2 (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .ch      (switch_2_ch)
  );

  assign o_enable   = enable_ch.level;
  assign o_switch_1 = switch_1_ch.level;
  assign o_switch_2 = switch_2_ch.level;

  // The pulse compares registered outputs only, so no raw input reaches it combinationally.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sel_q <= 2'b00;
    end else begin
      sel_q <= {o_switch_2, o_switch_1};
    end
  end

  assign o_sel_change = ({o_switch_2, o_switch_1} != sel_q);

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed latency/glitch/reset cases plus
// randomized switch activity compared every cycle against a sample-window model.
module tb_switch_debouncer;

  localparam int N = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sel_change;

  switch_debouncer_if en_bus ();
  switch_debouncer_if sw1_bus ();
  switch_debouncer_if sw2_bus ();

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  switch_debouncer #(.c_DEBOUNCE_CNT(N)) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_enable_raw   (en_bus.raw),
    .i_switch_1_raw (sw1_bus.raw),
    .i_switch_2_raw (sw2_bus.raw),
    .o_enable       (en_bus.level),
    .o_switch_1     (sw1_bus.level),
    .o_switch_2     (sw2_bus.level),
    .o_sel_change   (sel_change)
  );

  // Model: a level flips once the N raw samples that have crossed the two-flop
  // synchronizer all disagree with it. hist[c][0] is the newest raw sample.
  logic [N:0] hist [3];
  logic [2:0] exp_out;
  logic [2:0] nxt;
  logic       exp_sel;
  logic [2:0] raw_now;

  assign raw_now = {sw2_bus.raw, sw1_bus.raw, en_bus.raw};

  function automatic logic next_level(input logic [N:0] h, input logic cur);
    logic [N-1:0] w;
    w = h[N:1];
    if (cur) return (w == '0) ? 1'b0 : 1'b1;
    return (&w) ? 1'b1 : 1'b0;
  endfunction

  always_comb begin
    nxt = exp_out;
    for (int c = 0; c < 3; c++) nxt[c] = next_level(hist[c], exp_out[c]);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hist    <= '{default: '0};
      exp_out <= '0;
      exp_sel <= 1'b0;
    end else begin
      exp_out <= nxt;
      exp_sel <= (nxt[2:1] != exp_out[2:1]);
      for (int c = 0; c < 3; c++) hist[c] <= {hist[c][N-1:0], raw_now[c]};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    checkOutput("model_enable",     en_bus.level,  exp_out[0]);
    checkOutput("model_switch_1",   sw1_bus.level, exp_out[1]);
    checkOutput("model_switch_2",   sw2_bus.level, exp_out[2]);
    checkOutput("model_sel_change", sel_change,    exp_sel);
  end

  // Inputs move 1 time unit after the falling edge, clear of every sampling point.
  task automatic applyStimulus(input logic en, input logic s1, input logic s2);
    #1;
    en_bus.raw  = en;
    sw1_bus.raw = s1;
    sw2_bus.raw = s2;
  endtask

  task automatic setReset(input logic v);
    #1;
    reset = v;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  int pulses;
  int highs;
  logic [2:0] r;
  int hold;

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("reset_enable",     en_bus.level,  0);
    checkOutput("reset_switch_1",   sw1_bus.level, 0);
    checkOutput("reset_switch_2",   sw2_bus.level, 0);
    checkOutput("reset_sel_change", sel_change,    0);
    setReset(1'b0);
    waitEdges(3);

    // Clean rise on switch 1: output on edge N+2, one select pulse.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(N + 1);
    checkOutput("sw1_rise_early", sw1_bus.level, 0);
    waitEdges(1);
    checkOutput("sw1_rise_edge", sw1_bus.level, 1);
    checkOutput("sw1_rise_pulse", sel_change, 1);
    waitEdges(1);
    checkOutput("sw1_pulse_width", sel_change, 0);

    // Short enable glitch is rejected.
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    highs = 0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      waitEdges(1);
      highs += int'(en_bus.level);
      pulses += int'(sel_change);
    end
    checkOutput("enable_glitch_level", highs, 0);
    checkOutput("enable_glitch_pulse", pulses, 0);

    // Both selects rising together give a single pulse.
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitEdges(N + 4);
    applyStimulus(1'b0, 1'b1, 1'b1);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      waitEdges(1);
      pulses += int'(sel_change);
      if (i == N + 1) checkOutput("both_early", {sw2_bus.level, sw1_bus.level}, 0);
      if (i == N + 2) checkOutput("both_edge", {sw2_bus.level, sw1_bus.level}, 3);
    end
    checkOutput("both_one_pulse", pulses, 1);

    // Reset in the middle of a wait discards the partial count.
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitEdges(N + 4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitEdges(6);
    setReset(1'b1);
    #1;
    checkOutput("midreset_switch_2", sw2_bus.level, 0);
    checkOutput("midreset_sel", sel_change, 0);
    waitEdges(2);
    checkOutput("midreset_held", sw2_bus.level, 0);
    setReset(1'b0);
    waitEdges(1);
    checkOutput("release_no_pulse", sel_change, 0);
    waitEdges(N);
    checkOutput("after_reset_early", sw2_bus.level, 0);
    waitEdges(1);
    checkOutput("after_reset_edge", sw2_bus.level, 1);

    // Falling bounce on switch 1: latency counts from the final low level.
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitEdges(N + 4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitEdges(3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitEdges(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitEdges(N + 1);
    checkOutput("bounce_early", sw1_bus.level, 1);
    waitEdges(1);
    checkOutput("bounce_edge", sw1_bus.level, 0);

    // Enable toggles follow with fixed latency and never pulse the select flag.
    pulses = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= N + 4; i++) begin
      waitEdges(1);
      if (i > 1) pulses += int'(sel_change);
      if (i == N + 1) checkOutput("enable_rise_early", en_bus.level, 0);
      if (i == N + 2) checkOutput("enable_rise_edge", en_bus.level, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= N + 4; i++) begin
      waitEdges(1);
      pulses += int'(sel_change);
      if (i == N + 1) checkOutput("enable_fall_early", en_bus.level, 1);
      if (i == N + 2) checkOutput("enable_fall_edge", en_bus.level, 0);
    end
    checkOutput("enable_toggle_pulse", pulses, 0);

    // Random switch activity with occasional resets, checked by the model every cycle.
    for (int seg = 0; seg < 300; seg++) begin
      r = 3'($urandom_range(0, 7));
      applyStimulus(r[0], r[1], r[2]);
      if ($urandom_range(0, 24) == 0) begin
        setReset(1'b1);
        waitEdges($urandom_range(1, 3));
        setReset(1'b0);
      end
      hold = $urandom_range(1, 2 * N + 2);
      waitEdges(hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter c_DEBOUNCE_CNT, default 250, giving the number of consecutive stable clocks required to accept a change (10 ms at 25 kHz); legal range 2..65535.
REQ-002 The block SHALL have port i_clock, input, 1 bit: the single clock.
REQ-003 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_enable_raw, input, 1 bit: asynchronous raw enable switch.
REQ-005 The block SHALL have port i_switch_1_raw, input, 1 bit: asynchronous raw select switch 1.
REQ-006 The block SHALL have port i_switch_2_raw, input, 1 bit: asynchronous raw select switch 2.
REQ-007 The block SHALL have port o_enable, output, 1 bit: debounced enable, which drives the LED frequency selector i_enable.
REQ-008 The block SHALL have port o_switch_1, output, 1 bit: debounced switch 1, which drives selector i_switch_1.
REQ-009 The block SHALL have port o_switch_2, output, 1 bit: debounced switch 2, which drives selector i_switch_2.
REQ-010 The block SHALL have port o_sel_change, output, 1 bit: one-clock pulse signalling that the debounced select {o_switch_2, o_switch_1} changed.

Function
REQ-011 Each raw input SHALL pass through its own two-flop synchronizer before any other logic uses it.
REQ-012 Each channel SHALL implement a four-state FSM: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-013 In STABLE_LOW, a synchronized 1 SHALL move the FSM to WAIT_HIGH and load the counter with 1.
REQ-014 In STABLE_HIGH, a synchronized 0 SHALL move the FSM to WAIT_LOW and load the counter with 1.
REQ-015 In a WAIT state, while the synchronized input holds the new value, the counter SHALL increment by 1 per clock.
REQ-016 In a WAIT state, when the counter equals c_DEBOUNCE_CNT-1 and the input still holds the new value, the FSM SHALL enter the opposite STABLE state, toggle the debounced output on that edge, and clear the counter.
REQ-017 In a WAIT state, if the synchronized input returns to the old value, the FSM SHALL return to the previous STABLE state, clear the counter, and leave the output unchanged (glitch rejected).
REQ-018 Latency SHALL be exactly c_DEBOUNCE_CNT+2 clocks: with edge 1 the first edge to sample a clean new raw level, the output changes on edge c_DEBOUNCE_CNT+2.
REQ-019 Each channel's counter SHALL be 16 bits wide, SHALL never exceed c_DEBOUNCE_CNT-1, and SHALL never wrap.
REQ-020 Debounced outputs SHALL be driven directly from registers, with no combinational path from any raw input.
REQ-021 o_sel_change SHALL be 1 for exactly the first clock in which {o_switch_2, o_switch_1} differs from its value one clock earlier.
REQ-022 If both select channels change on the same edge, o_sel_change SHALL produce one pulse; if they change on different edges, it SHALL produce one pulse per edge.
REQ-023 A change of o_enable alone SHALL NOT assert o_sel_change.
REQ-024 Channels SHALL be fully independent: activity on one channel SHALL NOT affect another channel's counter or state.

Reset
REQ-025 While i_reset=1, all synchronizer flops, counters and outputs (o_enable, o_switch_1, o_switch_2, o_sel_change) SHALL be 0, and every FSM SHALL be in STABLE_LOW, regardless of clock activity.
REQ-026 Reset asserted mid-WAIT SHALL discard the partial count; after reset release, a raw input held high SHALL be accepted exactly c_DEBOUNCE_CNT+2 clocks later.
REQ-027 The edge that clears reset SHALL NOT produce an o_sel_change pulse.

Structure
REQ-028 FSM state encodings (2 bits) and the default debounce count SHALL reside in a shared constants include file used by all codebase blocks.
REQ-029 One channel (synchronizer, FSM and counter) SHALL be a sub-module named debounce_channel, instantiated three times; switch_debouncer SHALL add only the o_sel_change logic.

Verification (c_DEBOUNCE_CNT=8)
REQ-030 Stimulus: i_switch_1_raw 0->1, held. Required response: o_switch_1=1 on edge 10 exactly; o_sel_change=1 for one clock.
REQ-031 Stimulus: i_enable_raw high for 5 clocks, then low. Required response: o_enable stays 0; o_sel_change stays 0.
REQ-032 Stimulus: i_switch_2_raw and i_switch_1_raw both 0->1 on the same edge. Required response: both outputs rise on edge 10; exactly one o_sel_change pulse.
REQ-033 Stimulus: i_switch_2_raw rises; i_reset pulses at count 4; input stays high. Required response: outputs 0 during reset; o_switch_2 rises 10 clocks after reset release.
REQ-034 Stimulus: 1->0 bounce pattern (0 for 3 clocks, 1 for 2 clocks, then 0 held). Required response: o_switch_1 falls 10 clocks after the final 0 is first sampled.
REQ-035 Stimulus: i_enable_raw toggled while the select inputs are held. Required response: o_enable follows with latency 10; o_sel_change stays 0.
